// File: rtl/cacheline_pkg.sv
// Shared types and geometry for the cache-line to memory-burst adaptor.
package cacheline_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET      = $clog2(LINE_WIDTH / 8);
    localparam int CNT_WIDTH   = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } adaptor_state_t;

    typedef logic [LINE_WIDTH-1:0]  line_t;
    typedef logic [BURST_WIDTH-1:0] beat_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [CNT_WIDTH-1:0]   cnt_t;

    // Clear the byte-within-line bits so memory always sees a line-aligned address.
    function automatic addr_t line_align(input addr_t addr);
        return {addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Converts one line-wide cache request into BEATS memory beats (read or write)
// and presents a single one-cycle completion pulse back to the cache.
module cacheline_burst_adaptor
    import cacheline_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    adaptor_state_t state;
    adaptor_state_t state_next;
    cnt_t           cnt;
    line_t          buffer;
    addr_t          addr_q;
    logic           last_beat;

    assign last_beat = (cnt == cnt_t'(BEATS - 1));
    assign line_o    = buffer;
    assign address_o = addr_q;

    // State register, beat counter, line buffer and latched address.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the line buffer is reset (not left uninitialised like a RAM)
            // because line_o is architecturally visible and must read 0 after reset.
            state  <= IDLE;
            cnt    <= '0;
            buffer <= '0;
            addr_q <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    // Write has priority; resp_i is deliberately ignored here.
                    if (write_i) begin
                        addr_q <= line_align(address_i);
                        buffer <= line_i;
                    end else if (read_i) begin
                        addr_q <= line_align(address_i);
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        buffer[int'(cnt) * BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        cnt <= last_beat ? '0 : cnt + cnt_t'(1);
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt <= last_beat ? '0 : cnt + cnt_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and Moore outputs to memory and cache.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves a signal unassigned, which would infer a latch.
        state_next = state;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        burst_o    = '0;
        unique case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WR_BURST;
                end else if (read_i) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i && last_beat) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
            WR_BURST: begin
                write_o = 1'b1;
                burst_o = buffer[int'(cnt) * BURST_WIDTH +: BURST_WIDTH];
                if (resp_i && last_beat) begin
                    state_next = WR_DONE;
                end
            end
            WR_DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: stimulus pushes the expected completion, a monitor pops and
// compares on every resp_o, and a small memory model answers the burst side.
module tb_cacheline_burst_adaptor;
    import cacheline_pkg::*;

    typedef struct {
        bit    is_write;
        line_t line;
        addr_t addr;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    line_t line_i = '0;
    line_t line_o;
    addr_t address_i = '0;
    logic  read_i = 1'b0;
    logic  write_i = 1'b0;
    logic  resp_o;
    beat_t burst_i;
    beat_t burst_o;
    addr_t address_o;
    logic  read_o;
    logic  write_o;
    logic  resp_i;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    exp_t  exp_q[$];

    // Memory model configuration, set by the stimulus before each transaction.
    int    mem_n = 0;
    beat_t mem_beats [BEATS];
    bit    gap_pat[$];
    bit    stray = 1'b0;
    beat_t wr_cap [BEATS];

    // Memory model private state.
    bit    m_active = 1'b0;
    int    m_wait = 0;
    int    m_beat = 0;
    int    m_slot = 0;
    bit    m_strobe;

    bit    prev_resp = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cacheline_burst_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    task automatic check(input string name, input logic [LINE_WIDTH-1:0] act,
                         input logic [LINE_WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: registers the request, waits mem_n further cycles, then strobes
    // BEATS beats following gap_pat (1 = beat, 0 = gap; beyond the pattern, beat).
    initial begin
        resp_i  = 1'b0;
        burst_i = '0;
        forever begin
            @(negedge clk);
            resp_i  = 1'b0;
            burst_i = '0;
            if (rst || !(read_o || write_o)) begin
                m_active = 1'b0;
                if (!rst && stray) begin
                    resp_i  = 1'b1;
                    burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end else begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_wait   = mem_n + 1;
                    m_beat   = 0;
                    m_slot   = 0;
                    for (int i = 0; i < BEATS; i++) wr_cap[i] = '0;
                end
                if (m_wait > 0) begin
                    m_wait--;
                end else if (m_beat < BEATS) begin
                    m_strobe = (m_slot < gap_pat.size()) ? gap_pat[m_slot] : 1'b1;
                    m_slot++;
                    if (m_strobe) begin
                        resp_i = 1'b1;
                        if (read_o) burst_i = mem_beats[m_beat];
                        else        wr_cap[m_beat] = burst_o;
                        m_beat++;
                    end
                end
            end
        end
    end

    // Monitor: every resp_o completes the oldest expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_o) begin
            check("resp_single_cycle", prev_resp, 1'b0);
            check("resp_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("address_o", address_o, e.addr);
                if (e.is_write)
                    check("write_beats", {wr_cap[3], wr_cap[2], wr_cap[1], wr_cap[0]}, e.line);
                else
                    check("line_o", line_o, e.line);
            end
        end
        prev_resp = resp_o;
    end

    // Runs one request from an IDLE negedge to the IDLE negedge after resp_o.
    task automatic do_txn(input string name, input bit wr, input bit rd,
                          input addr_t addr, input line_t wline,
                          input line_t exp_line, input int latency);
        exp_t e;
        int   start;
        bit   done;
        bit   wrong;
        done  = 1'b0;
        wrong = 1'b0;
        e.is_write = wr;
        e.line     = exp_line;
        e.addr     = line_align(addr);
        exp_q.push_back(e);
        address_i = addr;
        line_i    = wline;
        write_i   = wr;
        read_i    = rd;
        @(posedge clk);
        #1 start = cyc;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((wr && read_o) || (!wr && write_o)) wrong = 1'b1;
            if (resp_o) done = 1'b1;
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        check({name, "_completed"}, done, 1'b1);
        if (done) check({name, "_latency"}, cyc - start, latency);
        else      void'(exp_q.pop_back());
        check({name, "_direction"}, wrong, 1'b0);
        @(negedge clk);
        check({name, "_after_read_o"},  read_o,  1'b0);
        check({name, "_after_write_o"}, write_o, 1'b0);
        check({name, "_after_resp_o"},  resp_o,  1'b0);
        check({name, "_after_burst_o"}, burst_o, '0);
    endtask

    function automatic line_t beats_line();
        return {mem_beats[3], mem_beats[2], mem_beats[1], mem_beats[0]};
    endfunction

    initial begin
        line_t wl;

        // Reset state, sampled while rst is still high.
        repeat (3) @(negedge clk);
        check("rst_read_o",    read_o,    1'b0);
        check("rst_write_o",   write_o,   1'b0);
        check("rst_resp_o",    resp_o,    1'b0);
        check("rst_address_o", address_o, '0);
        check("rst_burst_o",   burst_o,   '0);
        check("rst_line_o",    line_o,    '0);
        rst = 1'b0;
        @(negedge clk);

        // Clean read, N=2.
        mem_n = 2;
        mem_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        do_txn("clean_read", 1'b0, 1'b1, 32'h0000_1234, '0, beats_line(), 7);
        check("clean_read_address", address_o, 32'h0000_1220);

        // Write-back, N=1: beats must leave lowest word first.
        mem_n = 1;
        wl = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
              64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        do_txn("write", 1'b1, 1'b0, 32'h8000_00FF, wl, wl, 6);
        check("write_address", address_o, 32'h8000_00E0);

        // Read with gaps between strobes, N=0: three gap cycles add latency.
        mem_n = 0;
        gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        mem_beats = '{64'h0F0F_0000_0000_0001, 64'h0F0F_0000_0000_0002,
                      64'h0F0F_0000_0000_0003, 64'h0F0F_0000_0000_0004};
        do_txn("gap_read", 1'b0, 1'b1, 32'h0000_4040, '0, beats_line(), 8);
        gap_pat.delete();

        // Read and write requested together: the write must win.
        wl = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        do_txn("both_high", 1'b1, 1'b1, 32'h0000_0100, wl, wl, 5);

        // Reset while the third beat of a read is being strobed.
        mem_n = 0;
        mem_beats = '{64'hEEEE_0000_0000_0000, 64'hEEEE_1111_0000_0000,
                      64'hEEEE_2222_0000_0000, 64'hEEEE_3333_0000_0000};
        address_i = 32'h0000_5000;
        read_i    = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        rst    = 1'b1;
        read_i = 1'b0;
        @(negedge clk);
        check("abort_read_o",    read_o,    1'b0);
        check("abort_resp_o",    resp_o,    1'b0);
        check("abort_line_o",    line_o,    '0);
        check("abort_address_o", address_o, '0);
        rst = 1'b0;
        @(negedge clk);

        // A fresh read after the abort completes normally.
        mem_n = 1;
        mem_beats = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                      64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
        do_txn("fresh_read", 1'b0, 1'b1, 32'h0000_3FFF, '0, beats_line(), 6);
        check("fresh_read_address", address_o, 32'h0000_3FE0);

        // Dirty miss: write-back then read, with stray strobes whenever idle.
        stray = 1'b1;
        mem_n = 0;
        wl = {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              64'hCAFE_F00D_CAFE_F00D, 64'hFACE_B00C_FACE_B00C};
        do_txn("dirty_write", 1'b1, 1'b0, 32'h0000_2000, wl, wl, 5);
        check("dirty_idle_line_o", line_o, wl);
        mem_n = 3;
        mem_beats = '{64'h9999_9999_9999_9999, 64'hA0A0_A0A0_A0A0_A0A0,
                      64'hB1B1_B1B1_B1B1_B1B1, 64'hC2C2_C2C2_C2C2_C2C2};
        do_txn("dirty_read", 1'b0, 1'b1, 32'h0000_2010, '0, beats_line(), 8);
        check("dirty_read_line_o", line_o, beats_line());
        repeat (2) @(negedge clk);
        check("dirty_idle_no_capture", line_o, beats_line());
        stray = 1'b0;

        check("all_responses_seen", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound in case a wait ever fails to terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
